// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the streaming matrix multiplier.
// Included by matmul_mac and matmul_stream.
package matmul_pkg;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        COMPUTE,
        OUT
    } matmul_state_t;

    // Result width: a full N-term sum of W x W products never overflows.
    function automatic int matmul_ow(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

    // Counter/index width that stays legal when the range collapses to one value.
    function automatic int matmul_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate unit: acc <= acc + a*b in one registered step.
// Define MATMUL_SIGNED_EN for two's-complement operands and accumulation.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int W  = 8,
    parameter int OW = matmul_ow(3, 8)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [OW-1:0] acc
);

    logic [2*W-1:0] prod;
    logic [OW-1:0]  prod_ext;

    always_comb begin
`ifdef MATMUL_SIGNED_EN
        prod     = $signed(a) * $signed(b);
        prod_ext = OW'($signed(prod));
`else
        prod     = a * b;
        prod_ext = OW'(prod);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/matmul_stream.sv
// Stream-interfaced N x N matrix multiplier (C = A*B) built around one MAC.
// Optional MATMUL_SIGNED_EN selects signed arithmetic inside matmul_mac.
module matmul_stream
    import matmul_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int W  = 8,
    localparam int OW = matmul_ow(N, W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    localparam int NN = N * N;
    localparam int IW = matmul_idx_w(N);
    localparam int AW = matmul_idx_w(NN);

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [AW-1:0] CNT_LAST = AW'(NN - 1);

    matmul_state_t state, state_n;

    logic [AW-1:0] cnt;
    logic [IW-1:0] i, j, k;

    logic [W-1:0]  a_buf [NN];
    logic [W-1:0]  b_buf [NN];
    logic [AW-1:0] a_idx, b_idx;
    logic [W-1:0]  mac_a, mac_b;

    logic in_hs, out_hs;
    logic mac_en, mac_clr;

    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign out_valid = (state == OUT);
    assign out_last  = out_valid && (i == IDX_LAST) && (j == IDX_LAST);
    assign busy      = !((state == LOAD_A) && (cnt == '0));

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_n = state;
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        case (state)
            LOAD_A: begin
                if (in_hs && (cnt == CNT_LAST)) begin
                    state_n = LOAD_B;
                end
            end
            LOAD_B: begin
                if (in_hs && (cnt == CNT_LAST)) begin
                    state_n = COMPUTE;
                    mac_clr = 1'b1;
                end
            end
            COMPUTE: begin
                mac_en = 1'b1;
                if (k == IDX_LAST) begin
                    state_n = OUT;
                end
            end
            OUT: begin
                if (out_hs) begin
                    mac_clr = 1'b1;
                    state_n = ((i == IDX_LAST) && (j == IDX_LAST)) ? LOAD_A : COMPUTE;
                end
            end
            default: state_n = LOAD_A;
        endcase
    end

    // Element counter for loads, k for the dot product, (i,j) for the output walk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            i   <= '0;
            j   <= '0;
            k   <= '0;
        end else begin
            case (state)
                LOAD_A, LOAD_B: begin
                    if (in_hs) begin
                        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                    end
                end
                COMPUTE: begin
                    k <= (k == IDX_LAST) ? '0 : k + 1'b1;
                end
                OUT: begin
                    if (out_hs) begin
                        if (j == IDX_LAST) begin
                            j <= '0;
                            i <= (i == IDX_LAST) ? '0 : i + 1'b1;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the operand buffers carry no reset; each entry is rewritten during
    // its load phase before COMPUTE can read it, so reset would only add cost.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            if (state == LOAD_A) begin
                a_buf[cnt] <= in_data;
            end else begin
                b_buf[cnt] <= in_data;
            end
        end
    end

    always_comb begin
        a_idx = AW'(int'(i) * N + int'(k));
        b_idx = AW'(int'(k) * N + int'(j));
        mac_a = a_buf[a_idx];
        mac_b = b_buf[b_idx];
    end

    // The accumulator doubles as the output register: it is frozen while in OUT.
    matmul_mac #(
        .W (W),
        .OW(OW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (mac_clr),
        .enable(mac_en),
        .a     (mac_a),
        .b     (mac_b),
        .acc   (out_data)
    );

endmodule
